// File: rtl/rf_sequencer.sv
// Register-transfer sequencer for a 2-entry register file: IDLE -> EXEC -> WRITE -> DONE.
// Define RF_SEQUENCER_SAT_EN to make ADD saturate at all-ones instead of wrapping.
module rf_sequencer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [1:0]   instr_op,
   input  logic         instr_dst,
   input  logic         instr_a,
   input  logic         instr_b,
   input  logic [N-1:0] instr_imm,
   output logic         rf_SA,
   output logic         rf_SB,
   output logic         rf_DA,
   output logic         rf_W,
   output logic [N-1:0] rf_D,
   input  logic [N-1:0] rf_A,
   input  logic [N-1:0] rf_B,
   output logic         res_valid,
   output logic [N-1:0] res_data,
   output logic         carry,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_MOV = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_RD  = 2'b11;

   // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both 1.
   state_t         state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic           dst_q, dst_d;
   logic           a_q, a_d;
   logic           b_q, b_d;
   logic [N-1:0]   imm_q, imm_d;
   logic [N-1:0]   result_q, result_d;
   logic           carry_q, carry_d;
   logic [N-1:0]   res_q, res_d;
   logic [N:0]     sum;
   logic [N-1:0]   exec_res;
   logic           accept;

   assign accept = instr_valid && instr_ready;
   assign sum    = {1'b0, rf_A} + {1'b0, rf_B};

   always_comb begin
      exec_res = rf_A;
      case (op_q)
         OP_LDI: exec_res = imm_q;
         OP_ADD: begin
`ifdef RF_SEQUENCER_SAT_EN
            exec_res = sum[N] ? {N{1'b1}} : sum[N-1:0];
`else
            exec_res = sum[N-1:0];
`endif
         end
         default: exec_res = rf_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= OP_LDI;
         dst_q    <= 1'b0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         imm_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dst_q    <= dst_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         res_q    <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = (op_q == OP_RD) ? DONE : WRITE;
         WRITE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // res_q only loads on the way into DONE so res_data is stable between strobes.
   always_comb begin
      op_d     = op_q;
      dst_d    = dst_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      result_d = result_q;
      carry_d  = carry_q;
      res_d    = res_q;
      if (state_q == IDLE && accept) begin
         op_d  = instr_op;
         dst_d = instr_dst;
         a_d   = instr_a;
         b_d   = instr_b;
         imm_d = instr_imm;
      end
      if (state_q == EXEC) begin
         result_d = exec_res;
         carry_d  = (op_q == OP_ADD) ? sum[N] : 1'b0;
      end
      if (state_d == DONE && state_q != DONE) res_d = result_d;
   end

   always_comb begin
      instr_ready = rst && (state_q == IDLE);
      rf_SA       = a_q;
      rf_SB       = b_q;
      rf_DA       = dst_q;
      rf_W        = (state_q == WRITE);
      rf_D        = (state_q == WRITE) ? result_q : '0;
      res_valid   = (state_q == DONE);
      res_data    = res_q;
      carry       = carry_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a behavioural 2x4 register file attached.
module tb_rf_sequencer;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         instr_valid;
   logic         instr_ready;
   logic [1:0]   instr_op;
   logic         instr_dst;
   logic         instr_a;
   logic         instr_b;
   logic [N-1:0] instr_imm;
   logic         rf_SA, rf_SB, rf_DA, rf_W;
   logic [N-1:0] rf_D, rf_A, rf_B;
   logic         res_valid;
   logic [N-1:0] res_data;
   logic         carry;
   logic [1:0]   dbg_state;

   logic [N-1:0] regs [2];
   int checks = 0;
   int errors = 0;

`ifdef RF_SEQUENCER_SAT_EN
   localparam logic [N-1:0] ADD_WRAP_EXP = 4'hF;
`else
   localparam logic [N-1:0] ADD_WRAP_EXP = 4'h3;
`endif

   rf_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_dst(instr_dst), .instr_a(instr_a), .instr_b(instr_b),
      .instr_imm(instr_imm),
      .rf_SA(rf_SA), .rf_SB(rf_SB), .rf_DA(rf_DA), .rf_W(rf_W), .rf_D(rf_D),
      .rf_A(rf_A), .rf_B(rf_B),
      .res_valid(res_valid), .res_data(res_data), .carry(carry), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign rf_A = regs[rf_SA];
   assign rf_B = regs[rf_SB];
   always @(posedge clk) if (rf_W) regs[rf_DA] <= rf_D;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic dst, input logic a, input logic b,
                        input logic [N-1:0] imm);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_dst   = dst;
      instr_a     = a;
      instr_b     = b;
      instr_imm   = imm;
   endtask

   // Accepts a write-class instruction from IDLE and runs it to DONE, checking its result.
   task automatic run_write(input string tag, input logic [1:0] op, input logic dst,
                            input logic a, input logic b, input logic [N-1:0] imm,
                            input logic [N-1:0] exp_res);
      drive(op, dst, a, b, imm);
      step();
      instr_valid = 1'b0;
      chk({tag, "_exec_w"}, {7'd0, rf_W}, 8'd0);
      step();
      chk({tag, "_write_w"}, {7'd0, rf_W}, 8'd1);
      chk({tag, "_write_d"}, {4'd0, rf_D}, {4'd0, exp_res});
      step();
      chk({tag, "_done_v"}, {7'd0, res_valid}, 8'd1);
      chk({tag, "_done_d"}, {4'd0, res_data}, {4'd0, exp_res});
      step();
   endtask

   initial begin
      rst = 1'b0;
      instr_valid = 1'b0;
      instr_op = 2'b00; instr_dst = 1'b0; instr_a = 1'b0; instr_b = 1'b0; instr_imm = '0;
      step(); step();
      chk("rst_ready", {7'd0, instr_ready}, 8'd0);
      chk("rst_w", {7'd0, rf_W}, 8'd0);
      chk("rst_valid", {7'd0, res_valid}, 8'd0);
      chk("rst_data", {4'd0, res_data}, 8'd0);
      chk("rst_carry", {7'd0, carry}, 8'd0);
      chk("rst_state", {6'd0, dbg_state}, 8'd0);
      rst = 1'b1;
      #1;
      chk("rel_ready", {7'd0, instr_ready}, 8'd1);

      // LDI R0=9: write 2 cycles after accept, strobe one cycle later
      drive(2'b00, 1'b0, 1'b0, 1'b0, 4'h9);
      step();
      instr_valid = 1'b0;
      chk("ldi_exec_ready", {7'd0, instr_ready}, 8'd0);
      chk("ldi_exec_w", {7'd0, rf_W}, 8'd0);
      step();
      chk("ldi_write_w", {7'd0, rf_W}, 8'd1);
      chk("ldi_write_da", {7'd0, rf_DA}, 8'd0);
      chk("ldi_write_d", {4'd0, rf_D}, 8'h09);
      chk("ldi_write_valid", {7'd0, res_valid}, 8'd0);
      step();
      chk("ldi_done_valid", {7'd0, res_valid}, 8'd1);
      chk("ldi_done_data", {4'd0, res_data}, 8'h09);
      chk("ldi_done_w", {7'd0, rf_W}, 8'd0);
      step();
      chk("ldi_idle_valid", {7'd0, res_valid}, 8'd0);
      chk("ldi_idle_hold", {4'd0, res_data}, 8'h09);
      chk("ldi_idle_ready", {7'd0, instr_ready}, 8'd1);
      chk("ldi_r0", {4'd0, regs[0]}, 8'h09);

      // MOV then RD
      run_write("ldi_r1", 2'b00, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3);
      run_write("mov", 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'h3);
      chk("mov_r0", {4'd0, regs[0]}, 8'h03);
      drive(2'b11, 1'b1, 1'b0, 1'b1, 4'h0);
      step();
      instr_valid = 1'b0;
      chk("rd_exec_w", {7'd0, rf_W}, 8'd0);
      chk("rd_exec_sa", {7'd0, rf_SA}, 8'd0);
      step();
      chk("rd_done_w", {7'd0, rf_W}, 8'd0);
      chk("rd_done_valid", {7'd0, res_valid}, 8'd1);
      chk("rd_done_data", {4'd0, res_data}, 8'h03);
      step();
      chk("rd_idle_ready", {7'd0, instr_ready}, 8'd1);
      chk("rd_r1", {4'd0, regs[1]}, 8'h03);

      // ADD with wrap: C + 7
      run_write("ldi_c", 2'b00, 1'b0, 1'b0, 1'b0, 4'hC, 4'hC);
      run_write("ldi_7", 2'b00, 1'b1, 1'b0, 1'b0, 4'h7, 4'h7);
      run_write("add_wrap", 2'b10, 1'b1, 1'b0, 1'b1, 4'h0, ADD_WRAP_EXP);
      chk("add_wrap_carry", {7'd0, carry}, 8'd1);
      chk("add_wrap_r1", {4'd0, regs[1]}, {4'd0, ADD_WRAP_EXP});

      // Back-to-back with valid held high; ADD R0=R0+R0 sees the LDI write
      drive(2'b00, 1'b0, 1'b0, 1'b0, 4'h5);
      step();
      drive(2'b10, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("b2b_exec_ready", {7'd0, instr_ready}, 8'd0);
      step();
      chk("b2b_write_ready", {7'd0, instr_ready}, 8'd0);
      step();
      chk("b2b_done_ready", {7'd0, instr_ready}, 8'd0);
      chk("b2b_ldi_data", {4'd0, res_data}, 8'h05);
      chk("b2b_ldi_carry", {7'd0, carry}, 8'd0);
      step();
      chk("b2b_idle_ready", {7'd0, instr_ready}, 8'd1);
      step();
      instr_valid = 1'b0;
      chk("b2b_add_exec", {6'd0, dbg_state}, 8'd1);
      step();
      chk("b2b_add_write_d", {4'd0, rf_D}, 8'h0A);
      step();
      chk("b2b_add_done_v", {7'd0, res_valid}, 8'd1);
      chk("b2b_add_data", {4'd0, res_data}, 8'h0A);
      chk("b2b_add_carry", {7'd0, carry}, 8'd0);
      step();
      chk("b2b_r0", {4'd0, regs[0]}, 8'h0A);

      // Reset during EXEC of LDI R1=E aborts the write
      drive(2'b00, 1'b1, 1'b0, 1'b0, 4'hE);
      step();
      instr_valid = 1'b0;
      chk("abort_in_exec", {6'd0, dbg_state}, 8'd1);
      rst = 1'b0;
      #1;
      chk("abort_rst_w", {7'd0, rf_W}, 8'd0);
      chk("abort_rst_state", {6'd0, dbg_state}, 8'd0);
      chk("abort_rst_ready", {7'd0, instr_ready}, 8'd0);
      step();
      chk("abort_hold_w", {7'd0, rf_W}, 8'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_post_w", {7'd0, rf_W}, 8'd0);
      end
      chk("abort_r1", {4'd0, regs[1]}, {4'd0, ADD_WRAP_EXP});
      chk("abort_ready", {7'd0, instr_ready}, 8'd1);
      chk("abort_state", {6'd0, dbg_state}, 8'd0);
      chk("abort_valid", {7'd0, res_valid}, 8'd0);
      chk("abort_data", {4'd0, res_data}, 8'd0);
      chk("abort_carry", {7'd0, carry}, 8'd0);
      chk("abort_rf_d", {4'd0, rf_D}, 8'd0);
      chk("abort_rf_sel", {5'd0, rf_DA, rf_SA, rf_SB}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
